wm_button_ctrl: RTL and testbench

//  Front-panel input conditioner for the washing machine; sits directly upstream of the cycle FSM.

---
 rtl/wm_button_ctrl_pkg.sv | 19 +
 rtl/wm_debounce.sv | 55 +++++
 rtl/wm_button_ctrl.sv | 96 +++++++++
 tb/tb_wm_button_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_button_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wm_button_ctrl_pkg
// Brief    : Shared state codes and defaults for the front-panel button block
// Revision : 1.0  initial release
// ============================================================================
package wm_button_ctrl_pkg;

  localparam int WMB_DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int WMB_CNT_W_DEFAULT           = 3;

  typedef logic [1:0] wmb_state_t;

  localparam wmb_state_t WMB_IDLE   = 2'd0;
  localparam wmb_state_t WMB_RUN    = 2'd1;
  localparam wmb_state_t WMB_PAUSED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/wm_debounce.sv
`default_nettype none
// ============================================================================
// Module   : wm_debounce
// Brief    : Two-flop synchroniser, saturating debounce counter, rise pulse
// Revision : 1.0  initial release
// ============================================================================
module wm_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             w_differ;

  assign w_differ = (r_sync[1] != r_level);

  // Counter runs only while the synchronised input disagrees with the level;
  // reaching the threshold flips the level, so the count never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw_in};
      r_rise <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt >= c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level_out  = r_level;
  assign rise_pulse = r_rise;

endmodule
`default_nettype wire

// File: rtl/wm_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wm_button_ctrl
// Brief    : Debounced start/pause buttons driving an IDLE/RUN/PAUSED latch
// Revision : 1.0  initial release
// ============================================================================
module wm_button_ctrl
  import wm_button_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = WMB_DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = WMB_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start_raw,
  input  logic pause_raw,
  input  logic cycle_done,
  output logic start_button,
  output logic pause_button,
  output logic start_pulse,
  output logic pause_pulse
);

  wmb_state_t r_state;
  wmb_state_t w_state_next;
  logic       w_start_level;
  logic       w_pause_level;
  logic       w_start_rise;
  logic       w_pause_rise;

  wm_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_start (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (start_raw),
    .level_out  (w_start_level),
    .rise_pulse (w_start_rise)
  );

  wm_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_pause (
    .clk        (clk),
    .reset      (reset),
    .raw_in     (pause_raw),
    .level_out  (w_pause_level),
    .rise_pulse (w_pause_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WMB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // cycle_done wins over any button pulse in the same cycle.
  always_comb begin
    w_state_next = WMB_IDLE;
    if (!cycle_done) begin
      case (r_state)
        WMB_IDLE:   w_state_next = w_start_rise ? WMB_RUN    : WMB_IDLE;
        WMB_RUN:    w_state_next = w_pause_rise ? WMB_PAUSED : WMB_RUN;
        WMB_PAUSED: w_state_next = w_pause_rise ? WMB_RUN    : WMB_PAUSED;
        default:    w_state_next = WMB_IDLE;
      endcase
    end
  end

  always_comb begin
    start_button = 1'b0;
    pause_button = 1'b0;
    case (r_state)
      WMB_RUN: begin
        start_button = 1'b1;
      end
      WMB_PAUSED: begin
        start_button = 1'b1;
        pause_button = 1'b1;
      end
      default: begin
        start_button = 1'b0;
        pause_button = 1'b0;
      end
    endcase
  end

  assign start_pulse = w_start_rise;
  assign pause_pulse = w_pause_rise;

endmodule
`default_nettype wire

// File: tb/tb_wm_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_button_ctrl
// Brief    : Directed + random bench for wm_button_ctrl with a behavioural model
// Revision : 1.0  initial release
// ============================================================================
module tb_wm_button_ctrl;
  import wm_button_ctrl_pkg::*;

  localparam int D = WMB_DEBOUNCE_CYCLES_DEFAULT;

  logic clk_tb = 1'b0;
  logic reset, start_raw, pause_raw, cycle_done;
  logic start_button, pause_button, start_pulse, pause_pulse;

  int checks = 0;
  int errors = 0;

  wm_button_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(WMB_CNT_W_DEFAULT)) dut (
    .clk          (clk_tb),
    .reset        (reset),
    .start_raw    (start_raw),
    .pause_raw    (pause_raw),
    .cycle_done   (cycle_done),
    .start_button (start_button),
    .pause_button (pause_button),
    .start_pulse  (start_pulse),
    .pause_pulse  (pause_pulse)
  );

  always #25 clk_tb = ~clk_tb;

  // Model: each button is seen two edges late; its level flips after D
  // consecutive edges of disagreement; the controller is a 3-way run latch.
  bit m_seen_q[2][$];
  bit m_level[2];
  bit m_pulse[2];
  int m_run[2];
  int m_state;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_seen_q[b] = '{1'b0, 1'b0};
      m_level[b]  = 1'b0;
      m_pulse[b]  = 1'b0;
      m_run[b]    = 0;
    end
    m_state = int'(WMB_IDLE);
  endfunction

  function automatic void model_edge(bit s_raw, bit p_raw, bit done);
    int  nxt;
    bit  seen;
    bit  raw_b;
    nxt = m_state;
    if (done) nxt = int'(WMB_IDLE);
    else if (m_state == int'(WMB_IDLE) && m_pulse[0]) nxt = int'(WMB_RUN);
    else if (m_state == int'(WMB_RUN) && m_pulse[1]) nxt = int'(WMB_PAUSED);
    else if (m_state == int'(WMB_PAUSED) && m_pulse[1]) nxt = int'(WMB_RUN);
    for (int b = 0; b < 2; b++) begin
      raw_b = (b == 0) ? s_raw : p_raw;
      seen = m_seen_q[b].pop_front();
      m_seen_q[b].push_back(raw_b);
      m_pulse[b] = 1'b0;
      if (seen != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_level[b] = !m_level[b];
          m_pulse[b] = m_level[b];
          m_run[b]   = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_state = nxt;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, "/start_button"}, start_button,
          (m_state == int'(WMB_RUN) || m_state == int'(WMB_PAUSED)));
    check({ctx, "/pause_button"}, pause_button, (m_state == int'(WMB_PAUSED)));
    check({ctx, "/start_pulse"}, start_pulse, m_pulse[0]);
    check({ctx, "/pause_pulse"}, pause_pulse, m_pulse[1]);
  endtask

  task automatic step(input string ctx);
    @(posedge clk_tb);
    if (!reset) model_reset();
    else model_edge(start_raw, pause_raw, cycle_done);
    @(negedge clk_tb);
    check_all(ctx);
  endtask

  task automatic steps(input int n, input string ctx);
    for (int i = 0; i < n; i++) step(ctx);
  endtask

  // Counts edges until the chosen pulse appears and how many pulses occur.
  task automatic watch(input int n, input bit which, input string ctx,
                       output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 1; i <= n; i++) begin
      step(ctx);
      if ((which ? pause_pulse : start_pulse) === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic done_pulse(input string ctx);
    cycle_done = 1'b1;
    step(ctx);
    cycle_done = 1'b0;
  endtask

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f, c;
    int s_hold, p_hold;
    reset = 1'b0; start_raw = 1'b1; pause_raw = 1'b0; cycle_done = 1'b0;
    model_reset();

    // 1: reset held with start pressed, then first pulse 6 edges after release
    steps(3, "t1_reset");
    reset = 1'b1;
    watch(10, 1'b0, "t1_release", f, c);
    check_int("t1_latency", f, D + 2);
    check_int("t1_count", c, 1);

    // 2: clean start press from IDLE
    done_pulse("t2_done");
    start_raw = 1'b0;
    steps(10, "t2_release");
    check("t2_idle", start_button, 1'b0);
    start_raw = 1'b1;
    watch(20, 1'b0, "t2_press", f, c);
    check_int("t2_latency", f, D + 2);
    check_int("t2_count", c, 1);
    check("t2_run", start_button, 1'b1);

    // 3: bouncing start press
    done_pulse("t3_done");
    start_raw = 1'b0;
    steps(10, "t3_release");
    start_raw = 1'b1; step("t3_b");
    start_raw = 1'b0; step("t3_b");
    start_raw = 1'b1; step("t3_b");
    start_raw = 1'b0; step("t3_b");
    start_raw = 1'b1;
    watch(15, 1'b0, "t3_steady", f, c);
    check_int("t3_latency", f, D + 2);
    check_int("t3_count", c, 1);

    // 4: two pause presses while running
    pause_raw = 1'b1;
    watch(10, 1'b1, "t4_p1", f, c);
    check_int("t4_p1_count", c, 1);
    check("t4_paused", pause_button, 1'b1);
    pause_raw = 1'b0;
    steps(20, "t4_gap");
    pause_raw = 1'b1;
    watch(10, 1'b1, "t4_p2", f, c);
    check_int("t4_p2_count", c, 1);
    check("t4_resumed", pause_button, 1'b0);
    check("t4_still_run", start_button, 1'b1);
    pause_raw = 1'b0;
    steps(10, "t4_release");

    // 5: cycle_done coincides with a pause pulse while PAUSED
    pause_raw = 1'b1; steps(10, "t5_pause");
    pause_raw = 1'b0; steps(10, "t5_release");
    check("t5_in_paused", pause_button, 1'b1);
    pause_raw = 1'b1;
    steps(D + 2, "t5_press");
    check("t5_pulse_now", pause_pulse, 1'b1);
    done_pulse("t5_clash");
    check("t5_sb_idle", start_button, 1'b0);
    check("t5_pb_idle", pause_button, 1'b0);
    pause_raw = 1'b0;
    start_raw = 1'b0;
    steps(10, "t5_release");

    // 6: asynchronous reset while PAUSED with pause held
    start_raw = 1'b1; steps(10, "t6_start");
    start_raw = 1'b0;
    pause_raw = 1'b1; steps(10, "t6_pause");
    check("t6_in_paused", pause_button, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    step("t6_in_reset");
    reset = 1'b1;
    watch(12, 1'b1, "t6_after", f, c);
    check_int("t6_latency", f, D + 2);
    check_int("t6_count", c, 1);
    check("t6_ignored", start_button, 1'b0);
    pause_raw = 1'b0;
    steps(10, "t6_release");

    // Random phase: buttons held for random spans, short spans act as glitches
    s_hold = 0;
    p_hold = 0;
    for (int i = 0; i < 2000; i++) begin
      if (s_hold == 0) begin
        start_raw = 1'($urandom_range(0, 1));
        s_hold = $urandom_range(1, 12);
      end
      if (p_hold == 0) begin
        pause_raw = 1'($urandom_range(0, 1));
        p_hold = $urandom_range(1, 12);
      end
      cycle_done = ($urandom_range(0, 24) == 0);
      s_hold--;
      p_hold--;
      step("rand");
    end
    cycle_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
